control_sequencer: RTL and testbench

Hardwired control unit for the single-bus CPU datapath. It fetches each instruction through PC/MAR/MDR/IR, then decodes the IR opcode. It issues the one-cycle-per-step register-transfer control signals (register out/in enables, Y/Z/HI/LO loads, ALU op select) that execute the instruction. It sits directly above the datapath and drives its control inputs in place of a bench-driven sequence.

---
 rtl/control_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the single-bus CPU datapath.
// Fetches through PC/MAR/MDR/IR, then decodes the IR opcode and issues
// one register-transfer step per clock.
//
// Optional feature macro: CTRL_MEM_WAIT_EN. When it is defined, T1 stalls
// on mem_ready and a fetch that never completes halts the sequencer.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   run_i        level: fetch/execute continuously while high
//   mem_ready_i  memory read data valid (used only with CTRL_MEM_WAIT_EN)
//   ir_i[31:0]   datapath IR: opcode[31:27] Ra[26:23] Rb[22:19] Rc[18:15]
//   reg_out_o    one-hot R0out..R15out
//   reg_in_o     one-hot R0in..R15in
//   bus_sel_o    {HIout, LOout, Zhighout, Zlowout, PCout, MDRout}
//   ld_o         {HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin}
//   read_o       memory read / MDR mux select
//   inc_pc_o     PC increment
//   alu_op_o     one-hot AND,OR,ADD,SUB,MUL,DIV,SHR,SHRA,SHL,ROR,ROL,NEG,NOT
//   busy_o       not IDLE and not HALTED
//   halted_o     HALTED
//   illegal_o    T3 pulse for an undefined opcode
//   mem_timeout_o sticky fetch-timeout flag
module control_sequencer #(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        run_i,
  input  logic        mem_ready_i,
  input  logic [31:0] ir_i,
  output logic [15:0] reg_out_o,
  output logic [15:0] reg_in_o,
  output logic [5:0]  bus_sel_o,
  output logic [7:0]  ld_o,
  output logic        read_o,
  output logic        inc_pc_o,
  output logic [12:0] alu_op_o,
  output logic        busy_o,
  output logic        halted_o,
  output logic        illegal_o,
  output logic        mem_timeout_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED
  } state_e;

  // bus_sel bit positions
  localparam int BS_MDR = 0, BS_PC = 1, BS_ZLO = 2, BS_ZHI = 3;
  // ld bit positions
  localparam int LD_MDR = 0, LD_MAR = 1, LD_Y = 2, LD_Z = 3;
  localparam int LD_IR = 4, LD_PC = 5, LD_LO = 6, LD_HI = 7;

  state_e state_q, state_d;

  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  assign opc = ir_i[31:27];
  assign ra  = ir_i[26:23];
  assign rb  = ir_i[22:19];
  assign rc  = ir_i[18:15];

  // Opcode classes and the ALU select they imply
  logic        c3, cmd, cun, chalt, cill;
  logic [12:0] alu_sel;

  always_comb begin
    c3      = 1'b0;
    cmd     = 1'b0;
    cun     = 1'b0;
    chalt   = 1'b0;
    cill    = 1'b0;
    alu_sel = '0;
    case (opc)
      5'd3:  begin c3  = 1'b1; alu_sel[2]  = 1'b1; end  // ADD
      5'd4:  begin c3  = 1'b1; alu_sel[3]  = 1'b1; end  // SUB
      5'd5:  begin c3  = 1'b1; alu_sel[0]  = 1'b1; end  // AND
      5'd6:  begin c3  = 1'b1; alu_sel[1]  = 1'b1; end  // OR
      5'd7:  begin c3  = 1'b1; alu_sel[9]  = 1'b1; end  // ROR
      5'd8:  begin c3  = 1'b1; alu_sel[10] = 1'b1; end  // ROL
      5'd9:  begin c3  = 1'b1; alu_sel[6]  = 1'b1; end  // SHR
      5'd10: begin c3  = 1'b1; alu_sel[7]  = 1'b1; end  // SHRA
      5'd11: begin c3  = 1'b1; alu_sel[8]  = 1'b1; end  // SHL
      5'd15: begin cmd = 1'b1; alu_sel[5]  = 1'b1; end  // DIV
      5'd16: begin cmd = 1'b1; alu_sel[4]  = 1'b1; end  // MUL
      5'd17: begin cun = 1'b1; alu_sel[11] = 1'b1; end  // NEG
      5'd18: begin cun = 1'b1; alu_sel[12] = 1'b1; end  // NOT
      5'd26: ;                                          // NOP
      5'd27: chalt = 1'b1;                              // HALT
      default: cill = 1'b1;
    endcase
  end

  // Where to go after an instruction's last step; run is sampled only here
  // and in IDLE, so dropping it mid-instruction finishes the instruction.
  state_e s_end;
  assign s_end = run_i ? S_T0 : S_IDLE;

`ifdef CTRL_MEM_WAIT_EN
  localparam int CW = $clog2(WAIT_MAX + 1);
  // Last waiting cycle: count WAIT_MAX-1 with mem_ready still low means
  // WAIT_MAX cycles have been spent in T1.
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          tmo_q, tmo_d;
  logic          unused_bits;
  assign unused_bits = ^ir_i[14:0];
`else
  logic          unused_bits;
  assign unused_bits = ^{mem_ready_i, ir_i[14:0]};
`endif

  always_comb begin
    state_d = state_q;
`ifdef CTRL_MEM_WAIT_EN
    wcnt_d  = wcnt_q;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: if (run_i) state_d = S_T0;
      S_T0: begin
        state_d = S_T1;
`ifdef CTRL_MEM_WAIT_EN
        wcnt_d  = '0;
`endif
      end
      S_T1: begin
`ifdef CTRL_MEM_WAIT_EN
        if (mem_ready_i) begin
          state_d = S_T2;
        end else if (wcnt_q == WAIT_LAST) begin
          state_d = S_HALTED;
          tmo_d   = 1'b1;
        end else begin
          wcnt_d  = wcnt_q + 1'b1;
        end
`else
        state_d = S_T2;
`endif
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (chalt)                 state_d = S_HALTED;
        else if (c3 || cmd || cun) state_d = S_T4;
        else                       state_d = s_end;
      end
      S_T4: state_d = (c3 || cmd) ? S_T5 : s_end;
      S_T5: state_d = cmd ? S_T6 : s_end;
      S_T6: state_d = s_end;
      S_HALTED: state_d = S_HALTED;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
`ifdef CTRL_MEM_WAIT_EN
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef CTRL_MEM_WAIT_EN
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

`ifdef CTRL_MEM_WAIT_EN
  assign mem_timeout_o = tmo_q;
`else
  assign mem_timeout_o = 1'b0;
`endif

  // Moore decode of state plus IR; reset forces IDLE so everything drops
  // in the same cycle reset is asserted.
  always_comb begin
    reg_out_o = '0;
    reg_in_o  = '0;
    bus_sel_o = '0;
    ld_o      = '0;
    read_o    = 1'b0;
    inc_pc_o  = 1'b0;
    alu_op_o  = '0;
    illegal_o = 1'b0;
    busy_o    = (state_q != S_IDLE) && (state_q != S_HALTED);
    halted_o  = (state_q == S_HALTED);
    case (state_q)
      S_T0: begin
        bus_sel_o[BS_PC] = 1'b1;
        ld_o[LD_MAR]     = 1'b1;
        ld_o[LD_PC]      = 1'b1;
        inc_pc_o         = 1'b1;
      end
      S_T1: begin
        read_o       = 1'b1;
        ld_o[LD_MDR] = 1'b1;
      end
      S_T2: begin
        bus_sel_o[BS_MDR] = 1'b1;
        ld_o[LD_IR]       = 1'b1;
      end
      S_T3: begin
        if (c3) begin
          reg_out_o  = 16'b1 << rb;
          ld_o[LD_Y] = 1'b1;
        end else if (cmd) begin
          reg_out_o  = 16'b1 << ra;
          ld_o[LD_Y] = 1'b1;
        end else if (cun) begin
          reg_out_o  = 16'b1 << rb;
          alu_op_o   = alu_sel;
          ld_o[LD_Z] = 1'b1;
        end else if (cill) begin
          illegal_o  = 1'b1;
        end
      end
      S_T4: begin
        if (c3 || cmd) begin
          reg_out_o  = 16'b1 << (c3 ? rc : rb);
          alu_op_o   = alu_sel;
          ld_o[LD_Z] = 1'b1;
        end else if (cun) begin
          bus_sel_o[BS_ZLO] = 1'b1;
          reg_in_o          = 16'b1 << ra;
        end
      end
      S_T5: begin
        if (c3) begin
          bus_sel_o[BS_ZLO] = 1'b1;
          reg_in_o          = 16'b1 << ra;
        end else if (cmd) begin
          bus_sel_o[BS_ZLO] = 1'b1;
          ld_o[LD_LO]       = 1'b1;
        end
      end
      S_T6: begin
        if (cmd) begin
          bus_sel_o[BS_ZHI] = 1'b1;
          ld_o[LD_HI]       = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a cycle table of {inputs, expected outputs}
// walked from reset, plus hand sequences for mid-instruction reset and
// (when CTRL_MEM_WAIT_EN is defined) the fetch timeout.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, run, mem_ready;
  logic [31:0] ir;
  logic [15:0] reg_out, reg_in;
  logic [5:0]  bus_sel;
  logic [7:0]  ld;
  logic        read, inc_pc, busy, halted, illegal, mem_timeout;
  logic [12:0] alu_op;

  control_sequencer #(.WAIT_MAX(15)) dut (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run), .mem_ready_i(mem_ready),
    .ir_i(ir), .reg_out_o(reg_out), .reg_in_o(reg_in), .bus_sel_o(bus_sel),
    .ld_o(ld), .read_o(read), .inc_pc_o(inc_pc), .alu_op_o(alu_op),
    .busy_o(busy), .halted_o(halted), .illegal_o(illegal),
    .mem_timeout_o(mem_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // flag nibble {busy, halted, illegal, mem_timeout}
  localparam logic [3:0] FB = 4'b1000, FH = 4'b0100, FI = 4'b1010, F0 = 4'b0000;

  localparam logic [31:0] I_MUL  = 32'h8130_0000;  // MUL R2,R6
  localparam logic [31:0] I_ADD  = 32'h1891_8000;  // ADD R1,R2,R3
  localparam logic [31:0] I_NEG  = 32'h8AB8_0000;  // NEG R5,R7
  localparam logic [31:0] I_ILL  = 32'hF800_0000;
  localparam logic [31:0] I_NOP  = 32'hD000_0000;
  localparam logic [31:0] I_HALT = 32'hD800_0000;

  typedef struct {
    string       nm;
    logic        run;
    logic [31:0] ir;
    logic [64:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [64:0] pk(logic [15:0] ro, logic [15:0] ri,
                                     logic [5:0] bs, logic [7:0] l,
                                     logic rd, logic inc, logic [12:0] alu,
                                     logic [3:0] fl);
    return {ro, ri, bs, l, rd, inc, alu, fl};
  endfunction

  function automatic void add(string nm, logic r, logic [31:0] i, logic [64:0] e);
    vec_t v;
    v.nm = nm; v.run = r; v.ir = i; v.exp = e;
    tbl.push_back(v);
  endfunction

  // T0: PCout, MARin, PCin, inc_pc; T1: read, MDRin; T2: MDRout, IRin
  localparam logic [64:0] E_T0 = {16'h0, 16'h0, 6'h02, 8'h22, 1'b0, 1'b1, 13'h0, FB};
  localparam logic [64:0] E_T1 = {16'h0, 16'h0, 6'h00, 8'h01, 1'b1, 1'b0, 13'h0, FB};
  localparam logic [64:0] E_T2 = {16'h0, 16'h0, 6'h01, 8'h10, 1'b0, 1'b0, 13'h0, FB};
  localparam logic [64:0] E_Z  = 65'h0;

  function automatic void fetch(string p, logic [31:0] i);
    add({p, "_t0"}, 1'b1, i, E_T0);
    add({p, "_t1"}, 1'b1, i, E_T1);
    add({p, "_t2"}, 1'b1, i, E_T2);
  endfunction

  task automatic check(string nm, logic [64:0] exp);
    logic [64:0] act;
    act = {reg_out, reg_in, bus_sel, ld, read, inc_pc, alu_op,
           busy, halted, illegal, mem_timeout};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; ir = 32'h0;

    // MUL R2,R6 back-to-back into ADD
    fetch("mul", I_MUL);
    add("mul_t3", 1'b1, I_MUL, pk(16'h0004, 16'h0, 6'h00, 8'h04, 0, 0, 13'h0, FB));
    add("mul_t4", 1'b1, I_MUL, pk(16'h0040, 16'h0, 6'h00, 8'h08, 0, 0, 13'h0010, FB));
    add("mul_t5", 1'b1, I_MUL, pk(16'h0, 16'h0, 6'h04, 8'h40, 0, 0, 13'h0, FB));
    add("mul_t6", 1'b1, I_MUL, pk(16'h0, 16'h0, 6'h08, 8'h80, 0, 0, 13'h0, FB));
    // ADD R1,R2,R3 with run dropped in T4 -> IDLE after T5
    fetch("add", I_ADD);
    add("add_t3", 1'b1, I_ADD, pk(16'h0004, 16'h0, 6'h00, 8'h04, 0, 0, 13'h0, FB));
    add("add_t4", 1'b0, I_ADD, pk(16'h0008, 16'h0, 6'h00, 8'h08, 0, 0, 13'h0004, FB));
    add("add_t5", 1'b0, I_ADD, pk(16'h0, 16'h0002, 6'h04, 8'h00, 0, 0, 13'h0, FB));
    add("idle0",  1'b0, I_ADD, E_Z);
    add("idle1",  1'b1, I_NEG, E_Z);
    // NEG R5,R7
    fetch("neg", I_NEG);
    add("neg_t3", 1'b1, I_NEG, pk(16'h0080, 16'h0, 6'h00, 8'h08, 0, 0, 13'h0800, FB));
    add("neg_t4", 1'b1, I_NEG, pk(16'h0, 16'h0020, 6'h04, 8'h00, 0, 0, 13'h0, FB));
    // undefined opcode: illegal pulse then straight to T0
    fetch("ill", I_ILL);
    add("ill_t3", 1'b1, I_ILL, pk(16'h0, 16'h0, 6'h00, 8'h00, 0, 0, 13'h0, FI));
    // NOP
    fetch("nop", I_NOP);
    add("nop_t3", 1'b1, I_NOP, pk(16'h0, 16'h0, 6'h00, 8'h00, 0, 0, 13'h0, FB));
    // HALT: stuck regardless of run
    fetch("hlt", I_HALT);
    add("hlt_t3", 1'b1, I_HALT, pk(16'h0, 16'h0, 6'h00, 8'h00, 0, 0, 13'h0, FB));
    add("hlt_a",  1'b0, I_HALT, pk(16'h0, 16'h0, 6'h00, 8'h00, 0, 0, 13'h0, FH));
    add("hlt_b",  1'b1, I_HALT, pk(16'h0, 16'h0, 6'h00, 8'h00, 0, 0, 13'h0, FH));
    add("hlt_c",  1'b0, I_HALT, pk(16'h0, 16'h0, 6'h00, 8'h00, 0, 0, 13'h0, FH));
    add("hlt_d",  1'b1, I_HALT, pk(16'h0, 16'h0, 6'h00, 8'h00, 0, 0, 13'h0, FH));

    // reset held with run=1
    #1 check("rst_a", E_Z);
    @(posedge clk); #1 check("rst_b", E_Z);
    @(negedge clk); rst_n = 1'b1;
    #1 check("rel_idle", E_Z);

    foreach (tbl[k]) begin
      @(negedge clk);
      run = tbl[k].run;
      ir  = tbl[k].ir;
      #1 check(tbl[k].nm, tbl[k].exp);
    end

    // reset out of HALTED, then reset mid-MUL in T4
    @(negedge clk); rst_n = 1'b0;
    #1 check("rst_halt", E_Z);
    @(negedge clk); rst_n = 1'b1; run = 1'b1; ir = I_MUL;
    repeat (5) @(negedge clk);
    #1 check("mr_t4", pk(16'h0040, 16'h0, 6'h00, 8'h08, 0, 0, 13'h0010, FB));
    #2 rst_n = 1'b0;
    #1 check("mr_async", E_Z);
    @(posedge clk); #1 check("mr_nohilo", E_Z);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 check("mr_t0", E_T0);

`ifdef CTRL_MEM_WAIT_EN
    // fetch never completes: T1 holds 15 cycles, then timeout + halt
    mem_ready = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1 check($sformatf("wait_t1_%0d", c), E_T1);
    end
    @(posedge clk); #1 check("tmo", pk(16'h0, 16'h0, 6'h00, 8'h00, 0, 0, 13'h0, 4'b0101));
    run = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1 check("tmo_hold", pk(16'h0, 16'h0, 6'h00, 8'h00, 0, 0, 13'h0, 4'b0101));
    @(negedge clk); rst_n = 1'b0;
    #1 check("tmo_clr", E_Z);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
